// File: rtl/ssio_sdr_out_diff_lanes_pkg.sv
// Shared types and helpers for the multi-lane SDR differential transmitter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: link state enum, PRBS7 constants, delay-width and seed helpers.
package ssio_pkg;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_TRAIN = 2'd1,
      ST_RUN   = 2'd2
   } ssio_state_t;

   // x^7 + x^6 + 1: feedback is the XOR of bits 6 and 5.
   localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
   localparam logic [6:0] PRBS7_SEED = 7'h7F;

   // Width of a per-lane delay field; never narrower than one bit.
   function automatic int ssio_dw(input int max_delay);
      int w;
      w = $clog2(max_delay + 1);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic logic [6:0] prbs7_step(input logic [6:0] s);
      return {s[5:0], ^(s & PRBS7_TAPS)};
   endfunction

   // Per-lane seed; an all-zero LFSR would lock up, so 0 maps to 1.
   function automatic logic [6:0] prbs7_lane_seed(input int lane);
      logic [6:0] s;
      s = PRBS7_SEED ^ 7'(lane);
      return (s == 7'h00) ? 7'h01 : s;
   endfunction

endpackage

// File: rtl/ssio_sdr_out_diff_lanes_if.sv
// Valid/ready word handshake between the MAC-side TX datapath and the transmitter.
// Latency: n/a (wires only). Backpressure: input_ready low outside RUN.
// Signals: input_d (word), input_valid, input_ready; master = source, slave = transmitter.
interface ssio_sdr_out_diff_lanes_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] input_d;
   logic             input_valid;
   logic             input_ready;

   modport master (output input_d, output input_valid, input input_ready);
   modport slave  (input input_d, input input_valid, output input_ready);
endinterface

// File: rtl/ssio_lane_delay.sv
// Single-lane deskew shift line with a registered tap select.
// Latency: 1 + tap cycles from din to dout. Backpressure: none, free-running.
// Ports: clk, rst_n, din (lane bit), load (latch delay_in), delay_in, dout (tapped bit).
module ssio_lane_delay #(
   parameter int MAX_DELAY = 3,
   parameter int DW        = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          din,
   input  logic          load,
   input  logic [DW-1:0] delay_in,
   output logic          dout
);

   localparam logic [DW-1:0] MAX_TAP = DW'(MAX_DELAY);

   logic [MAX_DELAY:0] line;
   logic [DW-1:0]      tap;

   // The line is deliberately not flushed when the tap changes; training
   // absorbs the few stale bits that repeat or drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line <= '0;
         tap  <= '0;
      end else begin
         line[0] <= din;
         for (int k = 1; k <= MAX_DELAY; k++) begin
            line[k] <= line[k-1];
         end
         if (load) begin
            tap <= (delay_in > MAX_TAP) ? MAX_TAP : delay_in;
         end
      end
   end

   assign dout = line[tap];

endmodule

// File: rtl/ssio_sdr_out_diff_lanes.sv
// Multi-lane source-synchronous SDR differential transmitter with forwarded clock,
// post-reset hold-off, link training, idle insertion and per-lane deskew delay.
// Latency: accept at edge N appears on lane n at edge N+1+delay[n]. Backpressure:
// input_ready is high only in RUN; words offered in HOLD/TRAIN are not taken.
// Ports: clk, rst_n, in_if (input_d/valid/ready), train_req, lane_delay,
// link_up, train_active, output_clk_p/n, output_q_p/n.
// Build option: define SSIO_PRBS7_TRAIN_EN to send per-lane PRBS7 during TRAIN
// instead of the alternating all-ones/all-zeros pattern.
module ssio_sdr_out_diff_lanes
   import ssio_pkg::*;
#(
   parameter int               WIDTH        = 4,
   parameter int               MAX_DELAY    = 3,
   parameter int               HOLD_LEN     = 16,
   parameter int               TRAIN_LEN    = 32,
   parameter logic [WIDTH-1:0] IDLE_PATTERN = '0,
   parameter logic [WIDTH-1:0] INVERT       = '0,
   localparam int              DW           = ssio_dw(MAX_DELAY)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ssio_sdr_out_diff_lanes_if.slave in_if,
   input  logic                   train_req,
   input  logic [WIDTH*DW-1:0]    lane_delay,
   output logic                   link_up,
   output logic                   train_active,
   output logic                   output_clk_p,
   output logic                   output_clk_n,
   output logic [WIDTH-1:0]       output_q_p,
   output logic [WIDTH-1:0]       output_q_n
);

   localparam int CNT_MAX = (HOLD_LEN > TRAIN_LEN) ? HOLD_LEN : TRAIN_LEN;
   localparam int CW      = $clog2(CNT_MAX + 1);

   ssio_state_t      state;
   logic [CW-1:0]    cnt;
   logic             fwd_en;
   logic             ready_q;
   logic             enter_train;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] word_nxt;
   logic [WIDTH-1:0] q;

`ifdef SSIO_PRBS7_TRAIN_EN
   logic [WIDTH-1:0][6:0] lfsr;
`endif

   // Training (re)starts when HOLD expires, or on a request outside HOLD.
   always_comb begin
      enter_train = 1'b0;
      case (state)
         ST_HOLD:  enter_train = (cnt == CW'(HOLD_LEN - 1));
         ST_TRAIN: enter_train = train_req;
         ST_RUN:   enter_train = train_req;
         default:  enter_train = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_HOLD;
         cnt          <= '0;
         fwd_en       <= 1'b0;
         ready_q      <= 1'b0;
         link_up      <= 1'b0;
         train_active <= 1'b0;
      end else if (enter_train) begin
         state        <= ST_TRAIN;
         cnt          <= '0;
         fwd_en       <= 1'b1;
         ready_q      <= 1'b0;
         link_up      <= 1'b0;
         train_active <= 1'b1;
      end else begin
         case (state)
            ST_HOLD: cnt <= cnt + 1'b1;
            ST_TRAIN: begin
               if (cnt == CW'(TRAIN_LEN - 1)) begin
                  state        <= ST_RUN;
                  cnt          <= '0;
                  ready_q      <= 1'b1;
                  link_up      <= 1'b1;
                  train_active <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RUN: ;
            default: state <= ST_HOLD;
         endcase
      end
   end

   assign in_if.input_ready = ready_q;

`ifdef SSIO_PRBS7_TRAIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < WIDTH; n++) lfsr[n] <= prbs7_lane_seed(n);
      end else if (enter_train) begin
         for (int n = 0; n < WIDTH; n++) lfsr[n] <= prbs7_lane_seed(n);
      end else if (state == ST_TRAIN) begin
         for (int n = 0; n < WIDTH; n++) lfsr[n] <= prbs7_step(lfsr[n]);
      end
   end
`endif

   // Word selection uses the pre-edge state, so a word accepted on the same
   // edge as a training request is still loaded and transmitted.
   always_comb begin
      word_nxt = '0;
      case (state)
         ST_HOLD: word_nxt = '0;
         ST_TRAIN: begin
`ifdef SSIO_PRBS7_TRAIN_EN
            for (int n = 0; n < WIDTH; n++) word_nxt[n] = lfsr[n][6];
`else
            word_nxt = cnt[0] ? '0 : '1;
`endif
         end
         ST_RUN:  word_nxt = in_if.input_valid ? in_if.input_d : IDLE_PATTERN;
         default: word_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) word <= '0;
      else        word <= word_nxt;
   end

   for (genvar n = 0; n < WIDTH; n++) begin : g_lane
      ssio_lane_delay #(
         .MAX_DELAY (MAX_DELAY),
         .DW        (DW)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .din      (word[n]),
         .load     (enter_train),
         .delay_in (lane_delay[n*DW +: DW]),
         .dout     (q[n])
      );
   end

   // Inverted clock puts the receiver's rising edge in the middle of the eye.
   assign output_clk_p = ~clk & fwd_en;
   assign output_clk_n = ~output_clk_p;

   assign output_q_p = q ^ INVERT;
   assign output_q_n = ~output_q_p;

endmodule

// File: tb/tb_ssio_sdr_out_diff_lanes.sv
// Randomized self-checking bench for ssio_sdr_out_diff_lanes against a
// timeline model: word history per edge, phase derived from edge counts.
module tb_ssio_sdr_out_diff_lanes;

   localparam int         W    = 4;
   localparam int         HL   = 16;
   localparam int         TL   = 32;
   localparam int         MD   = 3;
   localparam logic [3:0] INV  = 4'b0101;
   localparam logic [3:0] IDLE = 4'h0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       train_req = 1'b0;
   logic [7:0] lane_delay = 8'h00;
   logic       link_up, train_active, oclk_p, oclk_n;
   logic [3:0] q_p, q_n;

   ssio_sdr_out_diff_lanes_if #(.WIDTH(W)) tx_if ();

   ssio_sdr_out_diff_lanes #(
      .WIDTH(W), .MAX_DELAY(MD), .HOLD_LEN(HL), .TRAIN_LEN(TL),
      .IDLE_PATTERN(IDLE), .INVERT(INV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_if(tx_if), .train_req(train_req),
      .lane_delay(lane_delay), .link_up(link_up), .train_active(train_active),
      .output_clk_p(oclk_p), .output_clk_n(oclk_n),
      .output_q_p(q_p), .output_q_n(q_n)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         e;            // posedges since reset release
   int         train_start;  // edge at which the latest training began
   int         dly [W];
   logic [3:0] hist [0:1023];  // word loaded into the word register at each edge

   // 0 = HOLD, 1 = TRAIN, 2 = RUN, as seen after edge k.
   function automatic int st_after(input int k);
      if (k < HL) return 0;
      if (k < train_start + TL) return 1;
      return 2;
   endfunction

   function automatic logic prbs_bit(input int lane, input int idx);
      logic [6:0] s;
      s = 7'h7F ^ 7'(lane);
      if (s == 7'h00) s = 7'h01;
      for (int i = 0; i < idx; i++) s = {s[5:0], s[6] ^ s[5]};
      return s[6];
   endfunction

   function automatic logic [3:0] train_word(input int idx);
      logic [3:0] w;
`ifdef SSIO_PRBS7_TRAIN_EN
      for (int n = 0; n < W; n++) w[n] = prbs_bit(n, idx);
`else
      w = (idx % 2 == 0) ? 4'hF : 4'h0;
`endif
      return w;
   endfunction

   task automatic reset_model();
      e = 0;
      train_start = HL;
      for (int n = 0; n < W; n++) dly[n] = 0;
   endtask

   task automatic check_reset(input string tag);
      logic [3:0] inv_n;
      inv_n = ~INV;
      check({tag, "_q_p"}, q_p, INV);
      check({tag, "_q_n"}, q_n, inv_n);
      check({tag, "_ready"}, tx_if.input_ready, 1'b0);
      check({tag, "_link"}, link_up, 1'b0);
      check({tag, "_train"}, train_active, 1'b0);
      check({tag, "_clk_p"}, oclk_p, 1'b0);
      check({tag, "_clk_n"}, oclk_n, 1'b1);
   endtask

   // One clock: apply inputs, advance model on the edge, check at +1 and +6.
   task automatic cycle(input logic v, input logic [3:0] d, input logic tr, input logic [7:0] ld);
      logic [3:0] w, expq, exp_p, exp_n;
      int pre, post, k, lv;
      tx_if.input_valid = v;
      tx_if.input_d     = d;
      train_req         = tr;
      lane_delay        = ld;
      @(posedge clk);
      e++;
      pre = st_after(e - 1);
      if (pre == 0)      w = 4'h0;
      else if (pre == 1) w = train_word(e - 1 - train_start);
      else               w = v ? d : IDLE;
      if (e < 1024) hist[e] = w;
      if ((pre == 0 && e == HL) || (pre != 0 && tr)) begin
         train_start = e;
         for (int n = 0; n < W; n++) begin
            lv = int'(ld[2*n +: 2]);
            dly[n] = (lv > MD) ? MD : lv;
         end
      end
      #1;
      for (int n = 0; n < W; n++) begin
         k = e - 1 - dly[n];
         expq[n] = (k >= 1 && k < 1024) ? hist[k][n] : 1'b0;
      end
      exp_p = expq ^ INV;
      exp_n = ~exp_p;
      post = st_after(e);
      check("q_p", q_p, exp_p);
      check("q_n", q_n, exp_n);
      check("ready", tx_if.input_ready, post == 2);
      check("link_up", link_up, post == 2);
      check("train_active", train_active, post == 1);
      check("clk_p_hi", oclk_p, 1'b0);
      #5;
      check("clk_p_lo", oclk_p, e >= HL);
      check("clk_n_lo", oclk_n, e < HL);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, lane_delay);
   endtask

   initial begin
      logic [7:0] ld;
      tx_if.input_valid = 1'b0;
      tx_if.input_d     = 4'h0;
      reset_model();

      // Reset entry and steady reset state in both clock phases.
      #2 rst_n = 1'b0;
      #1 check_reset("rst");
      repeat (3) @(posedge clk);
      #6 check_reset("rst_lo");
      rst_n = 1'b1;

      // HOLD for 16, TRAIN for 32, link up at 48.
      idle(48);

      // Single word with zero delays, then idle.
      cycle(1'b1, 4'hA, 1'b0, 8'h00);
      idle(4);
      cycle(1'b1, 4'h0, 1'b0, 8'h00);
      idle(2);

      // Retrain with per-lane delays 0,1,2,3 and send all-ones.
      cycle(1'b0, 4'h0, 1'b1, 8'hE4);
      idle(33);
      cycle(1'b1, 4'hF, 1'b0, 8'hE4);
      idle(6);

      // Random traffic; lane_delay wiggles but must be ignored in RUN.
      for (int i = 0; i < 100; i++)
         cycle(1'($urandom), 4'($urandom), 1'b0, 8'($urandom));

      // Training request on the same edge as an accepted word.
      ld = 8'($urandom);
      cycle(1'b1, 4'h3, 1'b1, ld);
      for (int i = 0; i < 40; i++)
         cycle(1'($urandom), 4'($urandom), 1'b0, 8'($urandom));

      // Mixed traffic with occasional training requests in any state.
      for (int i = 0; i < 200; i++)
         cycle(1'($urandom), 4'($urandom), ($urandom_range(0, 24) == 0), 8'($urandom));
      for (int i = 0; i < 40; i++)
         cycle(1'($urandom), 4'($urandom), 1'b0, lane_delay);

      // Asynchronous reset between edges while in RUN.
      #2 rst_n = 1'b0;
      #1 check_reset("mid_rst");
      repeat (2) @(posedge clk);
      #6 check_reset("mid_rst_lo");
      reset_model();
      rst_n = 1'b1;
      for (int i = 0; i < 80; i++)
         cycle(1'($urandom), 4'($urandom), ($urandom_range(0, 39) == 0), 8'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
